// File: rtl/abs_diff_ctrl_ci_pkg.sv
// abs_diff_ctrl_ci_pkg: shared opcodes, FSM encodings and counter helpers for the optic_flow CIs
package abs_diff_ctrl_ci_pkg;
  localparam logic [1:0] OP_COMPUTE      = 2'd0;
  localparam logic [1:0] OP_SET_THR      = 2'd1;
  localparam logic [1:0] OP_GET_THR      = 2'd2;
  localparam logic [1:0] OP_READ_CLR_CNT = 2'd3;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAIR_HI = 2'd1;
  localparam logic [1:0] ST_PAIR_LO = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;
  localparam logic [7:0] THR_RST = 8'd15;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/abs_diff_ctrl_ci_unit.sv
// abs_diff_unit: combinational |a-b| with strict greater-than threshold flag
//   a, b : 8-bit unsigned operands
//   thr  : 8-bit unsigned threshold
//   diff : |a-b|, never wraps
//   flag : diff > thr
module abs_diff_unit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] thr,
  output logic [7:0] diff,
  output logic       flag
);
  always_comb begin
    diff = (a > b) ? a - b : b - a;
    flag = diff > thr;
  end
endmodule

// File: rtl/abs_diff_ctrl_ci.sv
// abs_diff_ctrl_ci: custom instruction flagging pixel pairs whose absolute difference exceeds a threshold
//   clock, nReset : rising-edge clock, async active-low reset
//   start, ciN    : request strobe and CI number (acts only on customInstructionId)
//   valueA        : pixel word {p3,p2,p1,p0} or config data in [7:0]
//   valueB        : opcode in [1:0]
//   done, result  : one-cycle completion pulse and its result (zero otherwise)
import abs_diff_ctrl_ci_pkg::*;
module abs_diff_ctrl_ci #(
  parameter logic [7:0] customInstructionId = 8'd30
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);
  logic [1:0] state;
  logic [31:0] pix;
  logic [7:0] thr;
  logic [CNT_W-1:0] flag_count;
  logic flag_hi;
  logic [31:0] res;
  logic [1:0] op;
  logic accept;
  logic [7:0] diff;
  logic flag;
  logic unused_b;
  assign op = valueB[1:0];
  assign unused_b = ^valueB[31:2];
  assign accept = state == ST_IDLE && start && ciN == customInstructionId;
  assign done = state == ST_DONE;
  assign result = done ? res : 32'd0;
  // one unit shared over time: high pair in PAIR_HI, low pair in PAIR_LO
  abs_diff_unit u_abs (
    .a    (state == ST_PAIR_HI ? pix[31:24] : pix[15:8]),
    .b    (state == ST_PAIR_HI ? pix[23:16] : pix[7:0]),
    .thr  (thr),
    .diff (diff),
    .flag (flag)
  );
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_IDLE;
      pix        <= '0;
      thr        <= THR_RST;
      flag_count <= '0;
      flag_hi    <= 1'b0;
      res        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state <= (op == OP_COMPUTE) ? ST_PAIR_HI : ST_DONE;
          if (op == OP_COMPUTE) pix <= valueA;
          if (op == OP_SET_THR) thr <= valueA[7:0];
          if (op == OP_READ_CLR_CNT) flag_count <= '0;
          res <= (op == OP_GET_THR) ? {24'd0, thr} :
                 (op == OP_READ_CLR_CNT) ? {16'd0, flag_count} : 32'd0;
        end
        ST_PAIR_HI: begin
          state   <= ST_PAIR_LO;
          flag_hi <= flag;
        end
        // counter updates only on completion so an aborted request leaves no trace
        ST_PAIR_LO: begin
          state      <= ST_DONE;
          res        <= {30'd0, flag_hi, flag};
          flag_count <= sat_add(flag_count, {1'b0, flag_hi} + {1'b0, flag});
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  logic [7:0] unused_diff;
  assign unused_diff = diff;
endmodule

// File: tb/tb_abs_diff_ctrl_ci.sv
// tb_abs_diff_ctrl_ci: scoreboard bench for abs_diff_ctrl_ci
module tb_abs_diff_ctrl_ci;
  logic clock = 1'b0;
  logic nReset = 1'b0;
  logic start = 1'b0;
  logic [7:0] ciN = 8'd0;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic done;
  logic [31:0] result;
  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  abs_diff_ctrl_ci #(.customInstructionId(8'd30)) dut (
    .clock  (clock),
    .nReset (nReset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (nReset) begin
      if (done) begin
        if (q.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else check("result", result, q.pop_front());
      end else check("result_idle", result, 32'd0);
    end
  end
  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] exp);
    int lat;
    lat = (op == 2'd0) ? 3 : 1;
    @(negedge clock);
    start = 1'b1;
    ciN = 8'd30;
    valueA = a;
    valueB = ($urandom() & 32'hFFFF_FFFC) | {30'd0, op};
    q.push_back(exp);
    @(posedge clock);
    #1 start = 1'b0;
    valueA = $urandom();
    for (int i = 1; i <= lat; i++) begin
      @(negedge clock);
      check("done_timing", {31'd0, done}, {31'd0, i == lat});
    end
  endtask
  initial begin
    repeat (2) @(negedge clock);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    nReset = 1'b1;
    start = 1'b1;
    ciN = 8'd47;
    for (int i = 0; i < 5; i++) begin
      valueA = $urandom();
      valueB = $urandom();
      @(negedge clock);
      check("gate_ci", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    ciN = 8'd30;
    for (int i = 0; i < 5; i++) begin
      valueB = $urandom() & 32'hFFFF_FFFC;
      @(negedge clock);
      check("gate_start", {31'd0, done}, 32'd0);
    end
    req(2'd0, {8'd40, 8'd17, 8'd17, 8'd19}, 32'd2);
    req(2'd0, {8'd31, 8'd37, 8'd17, 8'd19}, 32'd0);
    req(2'd0, {8'd4, 8'd57, 8'd37, 8'd19}, 32'd3);
    req(2'd3, 32'd0, 32'd3);
    req(2'd3, 32'd0, 32'd0);
    req(2'd1, 32'd20, 32'd0);
    req(2'd2, 32'd0, 32'd20);
    req(2'd0, {8'd4, 8'd57, 8'd37, 8'd19}, 32'd2);
    req(2'd1, 32'd53, 32'd0);
    req(2'd0, {8'd4, 8'd57, 8'd0, 8'd0}, 32'd0);
    req(2'd0, {8'd255, 8'd0, 8'd0, 8'd0}, 32'd2);
    @(negedge clock);
    start = 1'b1;
    valueA = {8'd255, 8'd0, 8'd255, 8'd0};
    valueB = 32'd0;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 nReset = 1'b0;
    void'(q.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset_no_done", {31'd0, done}, 32'd0);
    end
    nReset = 1'b1;
    req(2'd2, 32'd0, 32'd15);
    req(2'd3, 32'd0, 32'd0);
    @(negedge clock);
    start = 1'b1;
    valueA = {8'd40, 8'd17, 8'd17, 8'd19};
    valueB = 32'd0;
    q.push_back(32'd2);
    q.push_back(32'd2);
    @(posedge clock);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check("busy_done", {31'd0, done}, {31'd0, i == 3 || i == 7});
      if (i == 7) start = 1'b0;
    end
    req(2'd3, 32'd0, 32'd2);
    @(negedge clock);
    force dut.flag_count = 16'hFFFE;
    #1 release dut.flag_count;
    req(2'd0, {8'd255, 8'd0, 8'd255, 8'd0}, 32'd3);
    req(2'd0, {8'd255, 8'd0, 8'd255, 8'd0}, 32'd3);
    req(2'd3, 32'd0, 32'h0000_FFFF);
    req(2'd3, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    check("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/abs_diff_ctrl_ci.md
ABS_DIFF_CTRL_CI -- requirements
Module: abs_diff_ctrl_ci

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd30, the CI number this block answers to.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nReset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  CI start strobe from the CPU.
REQ-005 SHALL have port ciN  in  8  CI number; the block acts only when ciN == customInstructionId.
REQ-006 SHALL have port valueA  in  32  operand; pixel word {p3,p2,p1,p0} or config data in valueA[7:0].
REQ-007 SHALL have port valueB  in  32  operand; valueB[1:0] = opcode (0 COMPUTE, 1 SET_THR, 2 GET_THR, 3 READ_CLR_CNT), other bits ignored.
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port result  out  32  CI result; valid only while done=1.

Function
REQ-010 SHALL accept a request only when start=1, ciN matches and FSM is IDLE; all other start pulses are ignored, no done generated.
REQ-011 FSM states: IDLE, PAIR_HI, PAIR_LO, DONE; 2-bit encoding.
REQ-012 COMPUTE: IDLE->PAIR_HI on accept, latching valueA into a pixel register; PAIR_HI->PAIR_LO->DONE->IDLE unconditionally.
REQ-013 SHALL use one shared absolute-difference unit: PAIR_HI evaluates |p3-p2|, PAIR_LO evaluates |p1-p0|, 8-bit unsigned, no wrap (|4-57| = 53).
REQ-014 A pair is flagged when its absolute difference is strictly greater than the threshold register (8-bit unsigned).
REQ-015 COMPUTE result SHALL be {30'b0, flagHi, flagLo}; done asserted in the 3rd cycle after the accepting edge (latency 3).
REQ-016 SET_THR: threshold <= valueA[7:0] at accept edge; result 32'd0; done asserted in the cycle after accept (latency 1) via DONE state.
REQ-017 GET_THR: result {24'b0, threshold}; latency 1.
REQ-018 READ_CLR_CNT: result {16'b0, flagCount}; flagCount cleared at the same edge; latency 1.
REQ-019 flagCount SHALL be a 16-bit counter incremented once per flagged pair (0, 1 or 2 per COMPUTE), saturating at 16'hFFFF.
REQ-020 done SHALL be high exactly one cycle per accepted request; result SHALL be 32'd0 whenever done=0.
REQ-021 A start held high across DONE SHALL be accepted again only once FSM returns to IDLE (back-to-back throughput 1 request per 4 cycles COMPUTE, 2 cycles config).
REQ-022 Threshold change SHALL affect only requests accepted after the SET_THR completes.

Reset
REQ-023 nReset low SHALL asynchronously force: FSM IDLE, done 0, result 0, pixel register 0, flagCount 0, threshold 8'd15.
REQ-024 Reset mid-operation SHALL abort the request with no done pulse and no counter update; first accept possible on the first rising edge after nReset deasserts.

Structure
REQ-025 Opcode constants, FSM state encodings, reset threshold (8'd15) and counter width (16) SHALL live in a shared package/include for the optic_flow CIs.
REQ-026 The shared |a-b| > thr comparison SHALL be a combinational sub-module abs_diff_unit (inputs a, b, thr; outputs diff[7:0], flag).
REQ-027 RTL size target 120-400 lines including sub-module.

Verification
REQ-028 Gating: start=1, ciN=47, any operands -> done stays 0, result 0 for 5 cycles; start=0, ciN=30 -> same.
REQ-029 COMPUTE, default thr: valueA {40,17,17,19} -> result 2; {31,37,17,19} -> 0; {04,57,37,19} -> 3; each done exactly in cycle 3 after accept, flagCount then READ_CLR_CNT -> 3, second read -> 0.
REQ-030 SET_THR valueA=8'd20 then GET_THR -> 20; COMPUTE {04,57,37,19} -> 2 (18 not > 20); boundary SET_THR 53, COMPUTE {04,57,00,00} -> 0.
REQ-031 Busy rejection: start held high 8 cycles with COMPUTE -> exactly 2 done pulses, cycles 3 and 7.
REQ-032 Reset: nReset low during PAIR_LO -> no done, GET_THR -> 15, READ_CLR_CNT -> 0.
REQ-033 Saturation: 32769 COMPUTEs of {255,0,255,0} (force/preload acceptable) -> READ_CLR_CNT -> 16'hFFFF.
